hilo_muldiv_unit: RTL
=====================

// Module: hilo_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers, beside the combinational ALU in EX.
//  Takes the same X/Y operands and computes MULT/MULTU/DIV/DIVU over several clocks.
//  Holds the pipeline via busy and exposes HI/LO to the MFHI/MFLO path.
//  Supports MTHI/MTLO writes.
// PARAMETERS
//  WIDTH    32  operand/HI/LO width
//  MUL_LAT  2   clocks from accepted start to done for MULT/MULTU (>=1)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous reset, active-low
//  start  in   1      launch op; sampled only when busy=0
//  OP     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  X      in   WIDTH  multiplicand / dividend
//  Y      in   WIDTH  multiplier / divisor
//  flush  in   1      abort in-flight op (pipeline squash)
//  hi_we  in   1      MTHI write
//  lo_we  in   1      MTLO write
//  wdata  in   WIDTH  MTHI/MTLO data
//  busy   out  1      op in flight; EX stage stalls while 1
//  done   out  1      one-cycle pulse; HI/LO already hold the new result in this cycle
//  HI     out  WIDTH  registered HI (remainder / product[63:32])
//  LO     out  WIDTH  registered LO (quotient / product[31:0])
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, HI=0, LO=0. Takes priority over all else, including mid-op.
//  FSM IDLE->MUL->IDLE; IDLE->DIV->FIX->IDLE; any state->IDLE on flush.
//  Accept edge E0: start=1 & busy=0; operands/OP latched at E0; busy=1 from E0 until done rises.
//  MUL: full 64-bit product (signed for MULT, unsigned for MULTU), pipelined over MUL_LAT clocks.
//  MUL write: HI/LO written at E(MUL_LAT); done=1 for the following cycle; busy=0 in that cycle.
//  DIV: latch |X|,|Y| (DIVU raw); restoring radix-2, one quotient bit per edge E1..E32.
//  FIX: at E33 apply signs, write HI/LO; done pulses after E33 (33-cycle latency).
//  Signed divide: quotient truncates toward zero; remainder takes dividend sign.
//  Divide by zero: LO=all ones, HI=X; still in FIX timing unless early-out applies.
//  Overflow 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
//  start while busy=1: ignored, no queuing.
//  start with done=1: accepted (busy=0 that cycle).
//  flush: next state IDLE, busy=0 after that edge, no done, HI/LO keep their pre-op values.
//  flush + start in the same cycle: flush wins, start dropped.
//  hi_we/lo_we: write HI/LO at the edge, any state.
//  MTHI/MTLO vs result write: a result write at the same edge overrides it.
//  MTHI/MTLO during an op: a later result write overwrites both regs.
//  Multiplier bit-exact for all 2^64 operand pairs; no flags.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: in DIV/DIVU, if |X|<|Y| or Y==0, skip iterations.
//    Early-out path DIV->FIX at E1, done after E2 (2-cycle latency).
//    Early-out results: |X|<|Y| gives LO=0, HI=X; Y==0 gives divide-by-zero values.
//  MULDIV_EARLY_OUT_EN undefined: all divides take the full 33 cycles; results identical.
// STRUCTURE
//  Package muldiv_pkg:
//    OP encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
//    State enum: S_IDLE, S_MUL, S_DIV, S_FIX.
//    Constant DIV_STEPS=WIDTH.
//  Sub-module div_step: combinational one-bit restoring step, (rem,quo,divisor) -> (rem',quo').
//  The iteration counter, FSM and HI/LO registers stay in this module.
// TESTING
//  MULT X=0xFFFFFFFD Y=5 -> at done (2 clk after accept) HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  MULTU X=0xFFFFFFFF Y=2 -> HI=0x00000001, LO=0xFFFFFFFE.
//  DIV X=-7 Y=2 -> done 33 clk after accept; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIV X=-7 Y=2, busy=1 for 33 cycles -> second start mid-op ignored.
//  DIVU X=100 Y=0 -> LO=0xFFFFFFFF, HI=0x64. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  Preload HI=LO=0x55; DIVU 1000/3, flush at cycle 10 -> busy=0 next cycle, no done, HI=LO=0x55.
//  Same preload and op, rst_n=0 at cycle 10 -> HI=LO=0, busy=0.
//  Run with MULDIV_EARLY_OUT_EN: DIVU 3/1000 -> done 2 clk after accept, LO=0, HI=3.
//  Same 3/1000 without the macro -> same result at 33 clk.
//  Same edge as done: lo_we=1, wdata=0xAA -> LO equals the divide result, not 0xAA.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
// MULDIV_EARLY_OUT_EN (top-level build option) enables divide early-out.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int DIV_STEPS = XLEN;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_step.sv
// One restoring radix-2 divide step: shift in the next dividend bit,
// subtract the divisor if it fits, and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // quo holds the remaining dividend bits; its MSB feeds the remainder
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Build option MULDIV_EARLY_OUT_EN: divides with |X|<|Y| or Y==0 finish early.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = DIV_STEPS,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             sgn_q;
  logic             sx;
  logic             sy;
  logic             dz;
  logic             busy_q;
  logic             done_q;
  logic             sgn_in;
  logic             x_neg;
  logic             y_neg;
  logic             early;

  logic [2*WIDTH-1:0] ext_x;
  logic [2*WIDTH-1:0] ext_y;
  logic [2*WIDTH-1:0] prod;

  assign sgn_in = is_signed_op(OP);
  assign x_neg  = sgn_in & X[WIDTH-1];
  assign y_neg  = sgn_in & Y[WIDTH-1];

  // extension picks signed vs unsigned; low 2W bits are exact either way
  assign ext_x = {{WIDTH{sgn_q & x_q[WIDTH-1]}}, x_q};
  assign ext_y = {{WIDTH{sgn_q & y_q[WIDTH-1]}}, y_q};
  assign prod  = ext_x * ext_y;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (cnt == '0) && (dz || (quo < dvs));
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
      if (flush) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              x_q    <= X;
              y_q    <= Y;
              sgn_q  <= sgn_in;
              sx     <= x_neg;
              sy     <= y_neg;
              dz     <= (Y == '0);
              rem    <= '0;
              quo    <= x_neg ? -X : X;
              dvs    <= y_neg ? -Y : Y;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= OP[1] ? S_DIV : S_MUL;
            end
          end
          S_MUL: begin
            if (cnt == MUL_LAST) begin
              hi_q   <= prod[2*WIDTH-1:WIDTH];
              lo_q   <= prod[WIDTH-1:0];
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_DIV: begin
            if (early) begin
              rem   <= quo;
              quo   <= '0;
              state <= S_FIX;
            end else begin
              rem <= rem_next;
              quo <= quo_next;
              cnt <= cnt + CW'(1);
              if (cnt == DIV_LAST) state <= S_FIX;
            end
          end
          S_FIX: begin
            if (dz) begin
              hi_q <= x_q;
              lo_q <= '1;
            end else begin
              hi_q <= sx ? -rem : rem;
              lo_q <= (sx ^ sy) ? -quo : quo;
            end
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
